// File: rtl/handshake_constant_arbiter_if.sv
// Handshake bundle between NUM_INPUTS control requesters, the arbiter and the downstream consumer.
// The master modport is the arbiter's view; slave is the requester/consumer environment.
interface handshake_constant_arbiter_if #(
  parameter int unsigned NUM_INPUTS  = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INDEX_WIDTH = 2
);

  logic [NUM_INPUTS-1:0]  ctrl_valid;
  logic [NUM_INPUTS-1:0]  ctrl_ready;
  logic [DATA_WIDTH-1:0]  outs;
  logic [INDEX_WIDTH-1:0] outs_index;
  logic                   outs_valid;
  logic                   outs_ready;

  modport master (
    input  ctrl_valid,
    output ctrl_ready,
    output outs,
    output outs_index,
    output outs_valid,
    input  outs_ready
  );

  modport slave (
    output ctrl_valid,
    input  ctrl_ready,
    input  outs,
    input  outs_index,
    input  outs_valid,
    output outs_ready
  );

endinterface

// File: rtl/handshake_constant_arbiter.sv
// Round-robin arbiter sharing one constant source among NUM_INPUTS control-token requesters.
// The winner's index is carried through a one-entry registered output buffer.
module handshake_constant_arbiter #(
  parameter int unsigned NUM_INPUTS  = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter logic [63:0] CONST_VALUE = 64'd0,
  parameter int unsigned INDEX_WIDTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  handshake_constant_arbiter_if.master  bus
);

  // Width needed to address one bit of ctrl_valid
  localparam int unsigned SEL_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  logic                   full_q;
  logic                   full_d;
  logic [INDEX_WIDTH-1:0] index_q;
  logic [INDEX_WIDTH-1:0] index_d;
  logic [INDEX_WIDTH-1:0] ptr_q;
  logic [INDEX_WIDTH-1:0] ptr_d;

  logic                   can_accept_c;
  logic                   any_valid_c;
  logic                   take_c;
  logic [INDEX_WIDTH-1:0] winner_c;
  logic [INDEX_WIDTH-1:0] ptr_next_c;
  logic [NUM_INPUTS-1:0]  grant_c;

  // Round-robin search: first valid requester starting at ptr, wrapping at NUM_INPUTS
  always_comb begin
    int unsigned pos;
    grant_c     = '0;
    winner_c    = '0;
    any_valid_c = 1'b0;
    pos         = 0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      pos = 32'(ptr_q) + k;
      if (pos >= NUM_INPUTS) begin
        pos = pos - NUM_INPUTS;
      end
      if (!any_valid_c && bus.ctrl_valid[SEL_W'(pos)]) begin
        any_valid_c             = 1'b1;
        winner_c                = INDEX_WIDTH'(pos);
        grant_c[SEL_W'(pos)]    = 1'b1;
      end
    end
  end

  // Pointer advances past the winner; wrap happens at NUM_INPUTS-1, not at the field maximum
  always_comb begin
    ptr_next_c = winner_c + INDEX_WIDTH'(1);
    if (32'(winner_c) == NUM_INPUTS - 1) begin
      ptr_next_c = '0;
    end
  end

  // Buffer can take a token when empty or when its current token leaves this cycle
  assign can_accept_c = ~full_q | bus.outs_ready;
  assign take_c       = any_valid_c & can_accept_c & rst;

  // Token accept is one-hot on the winner, suppressed while stalled or in reset
  assign bus.ctrl_ready = grant_c & {NUM_INPUTS{can_accept_c & rst}};

  // Next-state for the output buffer and round-robin pointer
  always_comb begin
    full_d  = full_q;
    index_d = index_q;
    ptr_d   = ptr_q;
    if (take_c) begin
      full_d  = 1'b1;
      index_d = winner_c;
      ptr_d   = ptr_next_c;
    end else if (full_q && bus.outs_ready) begin
      full_d  = 1'b0;
    end
  end

  // State registers with synchronous active-low reset; reset drops any buffered token
  always_ff @(posedge clk) begin
    if (!rst) begin
      full_q  <= 1'b0;
      index_q <= '0;
      ptr_q   <= '0;
    end else begin
      full_q  <= full_d;
      index_q <= index_d;
      ptr_q   <= ptr_d;
    end
  end

  // Outputs come straight from registers; the payload is a fixed constant
  assign bus.outs_valid = full_q;
  assign bus.outs_index = index_q;
  assign bus.outs       = DATA_WIDTH'(CONST_VALUE);

endmodule

// File: tb/tb_handshake_constant_arbiter.sv
// Bench for handshake_constant_arbiter: a 4-input/32-bit instance and a 3-input/8-bit instance
// driven side by side and compared every cycle against a token-level reference model.
module tb_handshake_constant_arbiter;

  localparam logic [31:0] C4 = 32'hA5C3_5A3C;
  localparam logic [7:0]  C3 = 8'hE7;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  handshake_constant_arbiter_if #(.NUM_INPUTS(4), .DATA_WIDTH(32), .INDEX_WIDTH(2)) if4 ();
  handshake_constant_arbiter_if #(.NUM_INPUTS(3), .DATA_WIDTH(8),  .INDEX_WIDTH(2)) if3 ();

  handshake_constant_arbiter #(
    .NUM_INPUTS(4), .DATA_WIDTH(32), .CONST_VALUE(64'h0000_0000_A5C3_5A3C), .INDEX_WIDTH(2)
  ) u_dut4 (
    .clk(clk), .rst(rst), .bus(if4.master)
  );

  handshake_constant_arbiter #(
    .NUM_INPUTS(3), .DATA_WIDTH(8), .CONST_VALUE(64'h0000_0000_0000_01E7), .INDEX_WIDTH(2)
  ) u_dut3 (
    .clk(clk), .rst(rst), .bus(if3.master)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state per instance (0: 4 inputs, 1: 3 inputs)
  int m_full [2];
  int m_idx  [2];
  int m_ptr  [2];
  int sb0 [$];
  int sb1 [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First requester holding valid, scanning from ptr in circular order; -1 if none
  function automatic int rr_winner(input int n, input int ptr, input int valid);
    for (int k = 0; k < n; k++) begin
      int p;
      p = (ptr + k) % n;
      if (((valid >> p) & 1) == 1) return p;
    end
    return -1;
  endfunction

  task automatic check_one(input int d, input string nm, input int n, input logic r,
                           input int valid, input logic ordy,
                           input logic [3:0] ready_obs, input logic ov,
                           input logic [1:0] oi, input logic [31:0] outs_obs,
                           input logic [31:0] cexp, output int w, output bit acc);
    int front;
    w   = rr_winner(n, m_ptr[d], valid);
    acc = r && (w >= 0) && (m_full[d] == 0 || ordy);
    chk({nm, ".ctrl_ready"}, 64'(ready_obs), acc ? 64'(1 << w) : 64'd0);
    chk({nm, ".outs_valid"}, 64'(ov), 64'(m_full[d]));
    chk({nm, ".outs_index"}, 64'(oi), 64'(m_idx[d]));
    chk({nm, ".index_range"}, 64'(32'(oi) < n), 64'd1);
    if (ov === 1'b1) chk({nm, ".outs"}, 64'(outs_obs), 64'(cexp));
    // Scoreboard: every outs handshake must retire the oldest outstanding ctrl handshake
    if (ov === 1'b1 && ordy) begin
      if (d == 0 ? sb0.size() == 0 : sb1.size() == 0) begin
        chk({nm, ".extra_token"}, 64'd1, 64'd0);
      end else begin
        front = (d == 0) ? sb0.pop_front() : sb1.pop_front();
        chk({nm, ".sb_order"}, 64'(oi), 64'(front));
      end
    end
    if (acc) begin
      if (d == 0) sb0.push_back(w); else sb1.push_back(w);
    end
  endtask

  task automatic update_one(input int d, input int n, input logic r, input logic ordy,
                            input int w, input bit acc);
    if (!r) begin
      m_full[d] = 0; m_idx[d] = 0; m_ptr[d] = 0;
      if (d == 0) sb0.delete(); else sb1.delete();
    end else if (acc) begin
      m_full[d] = 1; m_idx[d] = w; m_ptr[d] = (w + 1) % n;
    end else if (m_full[d] == 1 && ordy) begin
      m_full[d] = 0;
    end
  endtask

  // One clock: drive at negedge, check after settling, then advance the model past posedge
  task automatic step(input logic r, input logic [3:0] v4, input logic o4,
                      input logic [2:0] v3, input logic o3);
    int w4, w3;
    bit a4, a3;
    @(negedge clk);
    rst = r;
    if4.ctrl_valid = v4; if4.outs_ready = o4;
    if3.ctrl_valid = v3; if3.outs_ready = o3;
    #1;
    check_one(0, "n4", 4, r, int'(v4), o4, if4.ctrl_ready, if4.outs_valid,
              if4.outs_index, if4.outs, C4, w4, a4);
    check_one(1, "n3", 3, r, int'(v3), o3, {1'b0, if3.ctrl_ready}, if3.outs_valid,
              if3.outs_index, {24'd0, if3.outs}, {24'd0, C3}, w3, a3);
    @(posedge clk);
    update_one(0, 4, r, o4, w4, a4);
    update_one(1, 3, r, o3, w3, a3);
  endtask

  initial begin
    rst = 1'b0;
    if4.ctrl_valid = '0; if4.outs_ready = 1'b1;
    if3.ctrl_valid = '0; if3.outs_ready = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_full[d] = 0; m_idx[d] = 0; m_ptr[d] = 0;
    end

    // Reset held with every requester valid: nothing accepted, nothing emitted
    repeat (3) step(1'b0, 4'b1111, 1'b1, 3'b111, 1'b1);

    // All valid after release: 0,1,2,3,0 on four inputs; 0,1,2,0,1,2,0 on three
    repeat (8) step(1'b1, 4'b1111, 1'b1, 3'b111, 1'b1);

    // Single requester 2 held: one-hot accept every cycle, no bubbles
    repeat (4) step(1'b1, 4'b0100, 1'b1, 3'b100, 1'b1);

    // Backpressure: first grant, then stall, then release
    step(1'b1, 4'b0011, 1'b1, 3'b011, 1'b1);
    repeat (3) step(1'b1, 4'b0011, 1'b0, 3'b011, 1'b0);
    repeat (2) step(1'b1, 4'b0011, 1'b1, 3'b011, 1'b1);

    // Simultaneous in/out with requester 3 only: pointer wraps to 0
    repeat (2) step(1'b1, 4'b1000, 1'b1, 3'b100, 1'b1);
    step(1'b1, 4'b0000, 1'b1, 3'b000, 1'b1);

    // Mid-operation reset while full and stalled discards the buffered token
    step(1'b1, 4'b0010, 1'b1, 3'b010, 1'b1);
    step(1'b1, 4'b0000, 1'b0, 3'b000, 1'b0);
    step(1'b0, 4'b0000, 1'b0, 3'b000, 1'b0);
    repeat (2) step(1'b1, 4'b0000, 1'b1, 3'b000, 1'b1);
    repeat (3) step(1'b1, 4'b1111, 1'b1, 3'b111, 1'b1);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      step(1'b1, 4'($urandom), ($urandom % 4) != 0, 3'($urandom), ($urandom % 3) != 0);
    end

    // Drain and confirm nothing is left outstanding beyond the buffered entry
    repeat (4) step(1'b1, 4'b0000, 1'b1, 3'b000, 1'b1);
    chk("n4.sb_drain", 64'(sb0.size()), 64'd0);
    chk("n3.sb_drain", 64'(sb1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
